// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM with wait-stated memory handshakes, timeout fault and sticky halt.
// Optional perf counters (cyc_cnt, instr_cnt) are compiled in with MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [5:0]         opCode,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ExtSel,
    output logic               RegDst,
    output logic               RegWre,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [2:0]         state,
    output logic               halted,
    output logic               fault,
`ifdef MULTICYCLE_PERF_CNT_EN
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        instr_cnt,
`endif
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam int              CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [2:0]       alu_op3;

    logic is_r, is_i, is_sw, is_lw, is_beq, is_bne, is_j, is_halt, is_legal;

    assign is_r     = (opCode[5:3] == 3'b000);
    assign is_i     = (opCode[5:3] == 3'b001);
    assign is_sw    = (opCode == 6'b110000);
    assign is_lw    = (opCode == 6'b110001);
    assign is_beq   = (opCode == 6'b110100);
    assign is_bne   = (opCode == 6'b110101);
    assign is_j     = (opCode == 6'b111000);
    assign is_halt  = (opCode == 6'b111111);
    assign is_legal = is_r | is_i | is_sw | is_lw | is_beq | is_bne | is_j | is_halt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcB   = 1'b0;
        alu_op3   = 3'b000;
        ExtSel    = 1'b0;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        illegal   = 1'b0;

        // ALU fields stay stable from EXE through WB so the datapath result holds.
        if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
            ALUSrcB = is_i | is_lw | is_sw;
            if (is_lw || is_sw)        alu_op3 = 3'b000;
            else if (is_beq || is_bne) alu_op3 = 3'b001;
            else                       alu_op3 = opCode[2:0];
            ExtSel = !(is_i && opCode[2]);
        end

        case (state_q)
            S_IF: begin
                InsMemRW = 1'b1;
                if (imem_ready) begin
                    // Held low while in reset so only InsMemRW is visible then.
                    IRWre   = Reset;
                    state_d = S_ID;
                end else if (MAX_WAIT > 0 && cnt_q == WAIT_LIM) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ID: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_j) begin
                    PCWre   = 1'b1;
                    PCSrc   = 2'b11;
                    state_d = S_IF;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_beq || is_bne) begin
                    PCWre   = 1'b1;
                    PCSrc   = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mRD = !is_sw;
                mWR = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (MAX_WAIT > 0 && cnt_q == WAIT_LIM) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                RegDst    = is_r;
                DBDataSrc = is_lw;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IF;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    assign halted_d = halted_q | (state_d == S_HALT);
    assign fault_d  = fault_q | (state_d == S_FAULT);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IF;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign ALUOp  = ALUOP_W'(alu_op3);
    assign state  = state_q;
    assign halted = halted_q;
    assign fault  = fault_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT && state_q != S_FAULT) cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (PCWre) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit that replaces the single-cycle decoder for the next CPU generation.
- FSM sequences each instruction through IF/ID/EXE/MEM/WB and handshakes with wait-stated instruction and data memories.
- Timeout fault, sticky halt, parametrised ALUOp width and wait limit.
- Sits between the IR/ALU/memories and the PC, register file and datapath muxes.

Parameters:
- ALUOP_W, 3, ALUOp output width; must be >= 3; upper bits driven 0.
- MAX_WAIT, 15, max cycles waiting for a ready in IF or MEM before FAULT; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- opCode  in  6  opcode from IR, valid from ID onward
- zero  in  1  ALU zero flag, valid in EXE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- PCWre  out  1  PC write enable
- PCSrc  out  2  00 PC+4, 01 branch target, 11 jump
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read request
- ALUSrcB  out  1  1 = immediate
- ALUOp  out  ALUOP_W  ALU function
- ExtSel  out  1  1 = sign extend, 0 = zero extend
- RegDst  out  1  1 = rd, 0 = rt
- RegWre  out  1  register file write
- DBDataSrc  out  1  1 = DMOut, 0 = ALU result
- mRD  out  1  data memory read request
- mWR  out  1  data memory write request
- state  out  3  FSM state
- halted  out  1  sticky halt flag
- fault  out  1  sticky timeout flag
- illegal  out  1  one-cycle illegal-opcode pulse

Behaviour:
- Opcode classes:
  - op[5:3]=000: R-ALU, ALUOp=op[2:0].
  - op[5:3]=001: I-ALU, ALUOp=op[2:0].
  - 110000: sw; 110001: lw.
  - 110100: beq; 110101: bne.
  - 111000: j.
  - 111111: halt.
  - Anything else is illegal.
- State encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Reset (Reset=0, async):
  - state=IF, wait counter=0, halted=fault=illegal=0.
  - All control outputs 0 except InsMemRW=1.
  - Mid-access reset drops mRD/mWR immediately.
- Output timing:
  - Outputs are combinational from state, opCode, zero and ready inputs.
  - Only state, wait counter and sticky flags are registered.
- Per-state behaviour:
  - IF:
    - InsMemRW=1.
    - imem_ready=1: IRWre=1 for that cycle, go to ID.
  - ID:
    - halt: go to HALT.
    - j: PCWre=1, PCSrc=11, go to IF.
    - illegal: illegal=1, PCWre=1, PCSrc=00, go to IF.
    - Otherwise go to EXE.
  - EXE:
    - ALU fields are driven in EXE and held through MEM/WB.
    - ALUSrcB=1 for I-ALU/lw/sw.
    - ALUOp=000 (add) for lw/sw; 001 (sub) for beq/bne.
    - ExtSel=0 only for I-ALU with op[2]=1, else 1.
    - beq/bne: PCWre=1; PCSrc=01 if (beq&zero)|(bne&!zero), else 00; go to IF.
    - lw/sw: go to MEM.
    - ALU classes: go to WB.
  - MEM:
    - mRD=1 (lw) or mWR=1 (sw), held until dmem_ready=1.
    - sw on ready: PCWre=1, PCSrc=00, go to IF.
    - lw on ready: go to WB.
  - WB:
    - RegWre=1, RegDst=1 for R-ALU only, DBDataSrc=1 for lw.
    - PCWre=1, PCSrc=00, go to IF.
  - HALT:
    - halted=1; all enables 0; remain until reset.
  - FAULT:
    - fault=1; all enables 0; remain until reset.
- Wait counter and timeout:
  - Counter clears on entering IF/MEM and increments each cycle ready=0.
  - If the counter equals MAX_WAIT (MAX_WAIT>0) while ready=0, go to FAULT.
  - Ready in the same cycle as the limit wins (no fault).
- Invariants:
  - PCWre asserts exactly once per retired instruction.
  - IRWre asserts exactly once per fetch.
  - ready inputs are ignored outside their states.
- Cycle counts per instruction (zero-wait memories): j/illegal 2, branch 3, ALU 4, sw 4, lw 5, each plus added wait cycles.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- With it:
  - Adds outputs cyc_cnt[31:0] and instr_cnt[31:0], reset 0.
  - cyc_cnt increments every cycle outside HALT/FAULT.
  - instr_cnt increments on every PCWre.
  - Both wrap at 2^32.
- Without it: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset low, then high with imem_ready=1, opCode=000010 -> state 0,1,2,4,0; RegWre=1 and RegDst=1 only in WB; ALUOp=010; one PCWre.
- lw (110001), dmem_ready low 3 cycles then high -> mRD high 4 cycles; WB with DBDataSrc=1, RegWre=1; total 8 cycles.
- beq with zero=1 -> PCWre=1, PCSrc=01 in EXE; bne with zero=1 -> PCSrc=00; both back to IF after 3 cycles.
- MAX_WAIT=4, imem_ready held 0 -> FAULT on 5th IF cycle, fault=1 sticky; Reset low -> IF, fault=0.
- opCode=101010 -> illegal=1 for one cycle in ID, PCWre=1, PCSrc=00; opCode=111111 -> halted=1, no further PCWre.
- Reset asserted mid-MEM of sw -> mWR drops before next clk edge, state=0.
